// File: rtl/stream_mux4_rr.sv
// stream_mux4_rr: 4-to-1 round-robin valid/ready merge with packet lock and registered output
module stream_mux4_rr #(
   parameter int W        = 8,
   parameter bit PKT_MODE = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [3:0]     in_valid,
   input  logic [4*W-1:0] in_data,
   input  logic [3:0]     in_last,
   output logic [3:0]     in_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic           out_last,
   output logic [1:0]     out_sel,
   input  logic           out_ready
);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t     state, state_n;
   logic [1:0] ptr, ptr_n, lock_ch, lock_ch_n, cand, g, idx;
   logic       found, load_en, xfer;
   // first valid channel at or after ptr; reverse scan so the nearest one wins
   always_comb begin
      cand  = ptr;
      found = 1'b0;
      idx   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (in_valid[idx]) begin
            cand  = idx;
            found = 1'b1;
         end
      end
   end
   // grant, handshake and arbiter next-state
   always_comb begin
      load_en   = !out_valid || out_ready;
      g         = (state == LOCKED) ? lock_ch : cand;
      in_ready  = (!rst && load_en && (state == LOCKED || found)) ? (4'b0001 << g) : 4'b0000;
      xfer      = |(in_valid & in_ready);
      state_n   = state;
      ptr_n     = ptr;
      lock_ch_n = lock_ch;
      if (xfer) begin
         if (PKT_MODE && !in_last[g]) begin
            state_n   = LOCKED;
            lock_ch_n = g;
         end else begin
            state_n = IDLE;
            ptr_n   = g + 2'd1;
         end
      end
   end
   // arbiter state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= 2'd0;
         lock_ch <= 2'd0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         lock_ch <= lock_ch_n;
      end
   end
   // output register: load on transfer, drain when accepted with nothing new
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sel   <= 2'd0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= in_data[g*W +: W];
         out_last  <= in_last[g];
         out_sel   <= g;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_stream_mux4_rr.sv
// tb_stream_mux4_rr: directed self-checking bench for stream_mux4_rr in both packet modes
module tb_stream_mux4_rr;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_valid, in_last, out_ready_v;
   logic [31:0] in_data;
   logic        out_ready;
   logic [3:0]  in_ready, in_ready_b;
   logic        out_valid, out_last, out_valid_b, out_last_b;
   logic [7:0]  out_data, out_data_b;
   logic [1:0]  out_sel, out_sel_b;
   int          total = 0, passed = 0, fails = 0;

   always #5 clk = ~clk;

   stream_mux4_rr #(.W(8), .PKT_MODE(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_sel(out_sel), .out_ready(out_ready)
   );

   stream_mux4_rr #(.W(8), .PKT_MODE(1'b0)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b),
      .out_sel(out_sel_b), .out_ready(out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      out_ready_v = '0;
      rst       = 1'b1;
      in_valid  = 4'b1111;
      in_last   = 4'b1111;
      in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      out_ready = 1'b1;
      #1;
      chk("rst_ready_async", in_ready, 4'b0000);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("rst_ready", in_ready, 4'b0000);
         chk("rst_valid", out_valid, 0);
         chk("rst_sel", out_sel, 0);
         chk("rst_data", out_data, 0);
      end
      rst = 1'b0;
      #1;
      chk("post_rst_ready", in_ready, 4'b0001);

      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rr_valid", out_valid, 1);
         chk("rr_sel", out_sel, k % 4);
         chk("rr_data", out_data, 8'hA0 + (k % 4));
      end
      in_valid = 4'b0000;
      tick();
      chk("rr_drain", out_valid, 0);

      in_valid = 4'b0101;
      in_last  = 4'b0001;
      in_data[16 +: 8] = 8'hC0;
      #1;
      chk("lock_ready0", in_ready, 4'b0100);
      tick();
      chk("lock_sel0", out_sel, 2);
      chk("lock_data0", out_data, 8'hC0);
      in_data[16 +: 8] = 8'hC1;
      #1;
      chk("lock_ready1", in_ready, 4'b0100);
      tick();
      chk("lock_sel1", out_sel, 2);
      chk("lock_data1", out_data, 8'hC1);
      chk("lock_last1", out_last, 0);
      in_data[16 +: 8] = 8'hC2;
      in_last = 4'b0101;
      #1;
      chk("lock_ready2", in_ready, 4'b0100);
      tick();
      chk("lock_sel2", out_sel, 2);
      chk("lock_data2", out_data, 8'hC2);
      chk("lock_last2", out_last, 1);
      in_valid = 4'b0001;
      #1;
      chk("unlock_ready", in_ready, 4'b0001);
      tick();
      chk("unlock_sel", out_sel, 0);
      chk("unlock_data", out_data, 8'hA0);
      in_valid = 4'b0000;
      tick();
      chk("lock_drain", out_valid, 0);

      out_ready = 1'b0;
      in_valid  = 4'b0010;
      in_last   = 4'b0010;
      in_data[8 +: 8] = 8'hB0;
      #1;
      chk("bp_ready_empty", in_ready, 4'b0010);
      tick();
      in_data[8 +: 8] = 8'hB1;
      #1;
      chk("bp_capture", out_data, 8'hB0);
      chk("bp_ready_full", in_ready, 4'b0000);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_hold_data", out_data, 8'hB0);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_ready", in_ready, 4'b0000);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 4'b0010);
      tick();
      chk("bp_next_valid", out_valid, 1);
      chk("bp_next_data", out_data, 8'hB1);
      in_valid = 4'b0000;
      tick();
      chk("bp_drain", out_valid, 0);

      in_valid = 4'b1000;
      in_last  = 4'b0000;
      in_data[24 +: 8] = 8'hD0;
      tick();
      chk("mid_sel0", out_sel, 3);
      in_data[24 +: 8] = 8'hD1;
      tick();
      chk("mid_data1", out_data, 8'hD1);
      in_valid = 4'b1010;
      #1;
      chk("mid_locked_ready", in_ready, 4'b1000);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", in_ready, 4'b0000);
      tick();
      chk("mid_rst_valid", out_valid, 0);
      rst = 1'b0;
      #1;
      chk("mid_regrant_ready", in_ready, 4'b0010);
      tick();
      chk("mid_regrant_sel", out_sel, 1);
      in_valid = 4'b0000;
      tick();

      rst = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 4'b0011;
      in_last  = 4'b0000;
      in_data  = {8'h00, 8'h00, 8'hE1, 8'hE0};
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("pm0_valid", out_valid_b, 1);
         chk("pm0_sel", out_sel_b, k % 2);
         chk("pm0_data", out_data_b, 8'hE0 + (k % 2));
         chk("pm0_last", out_last_b, 0);
      end
      in_last = 4'b0001;
      tick();
      chk("pm0_sel_last", out_sel_b, 0);
      chk("pm0_last_mirror", out_last_b, 1);
      in_valid = 4'b0000;
      tick();
      chk("pm0_drain", out_valid_b, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/stream_mux4_rr.md
Name: stream_mux4_rr

Overview:
- 4-to-1 streaming multiplexer with round-robin arbitration. It is the merge side of the team's 1x4 dmux (2-bit sel fan-out).
- Four valid/ready input channels are funnelled into one registered output stream.
- The 2-bit source channel index is carried alongside the data, so a downstream dmux can route by it.
- Packet-aware: once a channel is granted, it holds the output until its last beat.

Parameters:
- W, 8, data width of each channel and of the output.
- PKT_MODE, 1, 1 = grant held until a beat with last=1 transfers; 0 = re-arbitrate on every beat (last is passed through only).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  4  per-channel beat valid, bit n = channel n
- in_data  input  4*W  channel n data at bits [n*W +: W]
- in_last  input  4  per-channel end-of-packet flag
- in_ready  output  4  per-channel accept; at most one bit high
- out_valid  output  1  output register holds a beat
- out_data  output  W  registered data
- out_last  output  1  registered last flag
- out_sel  output  2  registered source channel index
- out_ready  input  1  downstream accept

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - State=IDLE, round-robin pointer ptr=0.
  - in_ready=4'b0000 combinationally while rst=1.
- load_en = !out_valid | out_ready. This is combinational, so in_ready depends combinationally on out_ready.
- Transfer on channel g: in_valid[g] & in_ready[g]. It loads out_data, out_last and out_sel=g, and sets out_valid=1 on the next edge.
- Latency: 1 cycle from input transfer to output. Throughput: 1 beat/cycle while out_ready=1.
- Output drain: if out_ready=1 and no transfer occurs, out_valid goes to 0. While out_valid=1 and out_ready=0, out_data/out_last/out_sel are held stable.
- State IDLE:
  - Candidate g = first channel with in_valid set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - in_ready[g] = load_en; all other in_ready bits are 0.
  - No candidate: in_ready=0 and state is unchanged.
- IDLE transitions on a transfer from g:
  - PKT_MODE=1 and in_last[g]=0: go to LOCKED, lock_ch=g, ptr unchanged.
  - in_last[g]=1, or PKT_MODE=0: stay IDLE, ptr=g+1 (mod 4, 2-bit wrap so 3 -> 0).
- State LOCKED:
  - in_ready[lock_ch] = load_en; all other channels are 0 regardless of their valid.
  - A transfer with in_last=1 returns to IDLE with ptr=lock_ch+1.
  - A transfer with in_last=0 stays LOCKED.
  - lock_ch deasserting in_valid mid-packet: stay LOCKED indefinitely (no timeout).
- Simultaneous events:
  - Output drain and new load in the same cycle are allowed (back-to-back beats).
  - Multiple requesters are resolved solely by ptr order.
- The arbiter never grants a channel whose in_valid=0. Idle cycles do not move ptr.
- Reset mid-packet: the locked packet is abandoned, any beat in the output register is discarded, and arbitration restarts with ptr=0.
- in_data/in_last of ungranted channels are ignored; no X propagates from them to the outputs.

Test Plan:
1. Reset:
   - rst=1 for 2 cycles with all in_valid=4'b1111 -> in_ready=0, out_valid=0, out_sel=0 throughout.
   - First cycle after release -> in_ready=4'b0001.
2. Round-robin, single-beat packets:
   - All four channels valid with last=1, data n=8'hA0+n, out_ready=1.
   - Required: out_sel sequence 0,1,2,3,0 with out_data A0,A1,A2,A3,A0, one per cycle, starting 1 cycle after the first transfer.
3. Packet lock (PKT_MODE=1):
   - ch2 sends 3 beats (last on beat 3) while ch0 is continuously valid.
   - Required: in_ready[0]=0 until ch2's last beat transfers; output shows 3 consecutive out_sel=2 beats, then out_sel=0 next (ptr=3 wraps to 0).
4. Backpressure:
   - out_ready=0 for 4 cycles with ch1 valid -> one beat captured, out_data held constant, in_ready=0 after the capture.
   - Restore out_ready=1 -> beat drains and the next ch1 beat follows with no gap.
5. Reset mid-packet:
   - ch3 locked after 2 of 5 beats; assert rst for 1 cycle.
   - Required: out_valid=0; next grant goes to the lowest valid channel starting from 0 (e.g. ch1 if only ch1 and ch3 valid).
6. PKT_MODE=0:
   - ch0 and ch1 both valid with last=0 -> out_sel alternates 0,1,0,1; out_last mirrors the input last flags.
